// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with a start/ready/done handshake and multi-cycle shifts.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier (opcode 10).
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic [3:0]       S,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             C_out,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             err
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;
    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef ALU_MUL_EN
        ST_MUL,
`endif
        ST_COMPLETE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [3:0]       op;

    logic [SW-1:0]    k;
    logic             is_shift;
    logic             accept;

    logic [W1-1:0]    sum;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] sc_d;
    logic             sc_co, sc_v, sc_err;

    logic [WIDTH-1:0] shift_step;
    logic             shift_co;

    logic             load;
    logic [WIDTH-1:0] d_nxt;
    logic             co_nxt, v_nxt, err_nxt;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [W1-1:0]      mul_sum;
    logic [2*WIDTH-1:0] prod_step;
`endif

    assign k        = B[SW-1:0];
    assign is_shift = (S == OP_SHR) || (S == OP_SHL) || (S == OP_ROR) || (S == OP_ROL);
    assign accept   = start && ((state == ST_IDLE) || (state == ST_COMPLETE));

    // Single-cycle result from the live operands; used only on an accept edge
    always_comb begin
        sum    = '0;
        b2     = B;
        sc_d   = '0;
        sc_co  = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (S)
            OP_ADD: begin
                sum   = {1'b0, A} + {1'b0, B} + W1'(C_in);
                sc_d  = sum[WIDTH-1:0];
                sc_co = sum[WIDTH];
                sc_v  = (A[WIDTH-1] == b2[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                b2    = ~B;
                sum   = {1'b0, A} + {1'b0, b2} + W1'(1);
                sc_d  = sum[WIDTH-1:0];
                sc_co = sum[WIDTH];
                sc_v  = (A[WIDTH-1] == b2[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: sc_d = A & B;
            OP_OR:  sc_d = A | B;
            OP_XOR: sc_d = A ^ B;
            OP_NOT: sc_d = ~A;
            // zero-amount shifts/rotates pass A through
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: sc_d = A;
            default: begin
                sc_d   = '0;
                sc_err = 1'b1;
            end
        endcase
    end

    // One bit position of the latched shift/rotate
    always_comb begin
        shift_step = acc;
        shift_co   = 1'b0;
        case (op)
            OP_SHR: begin
                shift_step = {1'b0, acc[WIDTH-1:1]};
                shift_co   = acc[0];
            end
            OP_SHL: begin
                shift_step = {acc[WIDTH-2:0], 1'b0};
                shift_co   = acc[WIDTH-1];
            end
            OP_ROR: shift_step = {acc[0], acc[WIDTH-1:1]};
            OP_ROL: shift_step = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add step: upper half accumulates A, whole product shifts right one bit
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step = {mul_sum, prod[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        d_nxt     = '0;
        co_nxt    = 1'b0;
        v_nxt     = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_COMPLETE: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    if (is_shift && (k != '0)) begin
                        state_nxt = ST_SHIFT;
                    end
`ifdef ALU_MUL_EN
                    else if (S == OP_MUL) begin
                        state_nxt = ST_MUL;
                    end
`endif
                    else begin
                        state_nxt = ST_COMPLETE;
                        load      = 1'b1;
                        d_nxt     = sc_d;
                        co_nxt    = sc_co;
                        v_nxt     = sc_v;
                        err_nxt   = sc_err;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ST_COMPLETE;
                    load      = 1'b1;
                    d_nxt     = shift_step;
                    co_nxt    = shift_co;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ST_COMPLETE;
                    load      = 1'b1;
                    d_nxt     = prod_step[WIDTH-1:0];
                    co_nxt    = |prod_step[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Working registers for multi-cycle operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            op    <= '0;
`ifdef ALU_MUL_EN
            prod  <= '0;
            mcand <= '0;
`endif
        end else if (accept) begin
            acc <= A;
            op  <= S;
            cnt <= CW'(k);
`ifdef ALU_MUL_EN
            if (S == OP_MUL) begin
                cnt   <= CW'(WIDTH);
                prod  <= {WIDTH'(0), B};
                mcand <= A;
            end
`endif
        end else if (state == ST_SHIFT) begin
            acc <= shift_step;
            cnt <= cnt - CW'(1);
        end
`ifdef ALU_MUL_EN
        else if (state == ST_MUL) begin
            prod <= prod_step;
            cnt  <= cnt - CW'(1);
        end
`endif
    end

    // Result, flags and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D     <= '0;
            C_out <= 1'b0;
            z     <= 1'b1;
            n     <= 1'b0;
            v     <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            done  <= load;
            ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_COMPLETE);
            if (load) begin
                D     <= d_nxt;
                C_out <= co_nxt;
                z     <= (d_nxt == '0);
                n     <= d_nxt[WIDTH-1];
                v     <= v_nxt;
                err   <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors pushed at issue, checked on done.
// Expectations for opcode 10 follow ALU_MUL_EN.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         C_in = 1'b0;
    logic [3:0]   S = '0;
    logic         ready, done, C_out, z, n, v, err;
    logic [W-1:0] D;

    typedef struct {
        int           id;
        logic [W-1:0] d;
        logic         co;
        logic         z;
        logic         n;
        logic         v;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in), .S(S),
        .ready(ready), .done(done), .D(D), .C_out(C_out), .z(z), .n(n), .v(v), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, id, act, expv);
        end
    endtask

    task automatic reset_checks(input int id);
        check("rst_D", id, 32'(D), 32'(0));
        check("rst_C_out", id, 32'(C_out), 32'(0));
        check("rst_z", id, 32'(z), 32'(1));
        check("rst_n", id, 32'(n), 32'(0));
        check("rst_v", id, 32'(v), 32'(0));
        check("rst_err", id, 32'(err), 32'(0));
        check("rst_done", id, 32'(done), 32'(0));
        check("rst_ready", id, 32'(ready), 32'(1));
    endtask

    // Drive one request at a negedge once ready; expected done edge = accept edge + lat - 1
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int id, input logic [W-1:0] d, input logic co,
                         input logic ov, input logic er, input int lat, input bit push,
                         input int force_cyc);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout (vec %0d): got ready=0 expected 1 within 100 cycles", id);
        end
        S = op; A = a; B = b; C_in = cin; start = 1'b1;
        if (push) begin
            e.id  = id;
            e.d   = d;
            e.co  = co;
            e.z   = (d == '0);
            e.n   = d[W-1];
            e.v   = ov;
            e.err = er;
            e.cyc = (force_cyc > 0) ? force_cyc : cyc + lat;
            last_cyc = e.cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("D", e.id, 32'(D), 32'(e.d));
                    check("C_out", e.id, 32'(C_out), 32'(e.co));
                    check("z", e.id, 32'(z), 32'(e.z));
                    check("n", e.id, 32'(n), 32'(e.n));
                    check("v", e.id, 32'(v), 32'(e.v));
                    check("err", e.id, 32'(err), 32'(e.err));
                    check("done_cycle", e.id, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int base;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks(0);
        @(negedge clk);
        rst = 1'b0;

        // op  a      b      cin id d      co v  er lat push force
        issue(4'd0, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 0, 1, 0, 1, 1, 0); idle();

        // reset during a multiply: aborted op must never signal done
`ifdef ALU_MUL_EN
        issue(4'd10, 8'd3, 8'd5, 1'b0, 2, 8'h00, 0, 0, 0, 1, 0, 0);
`else
        issue(4'd10, 8'd3, 8'd5, 1'b0, 2, 8'h00, 0, 0, 1, 1, 1, 0);
`endif
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks(2);
        @(negedge clk);
        rst = 1'b0;

        issue(4'd0, 8'h01, 8'h01, 1'b0, 3, 8'h02, 0, 0, 0, 1, 1, 0); idle();
        issue(4'd0, 8'hFF, 8'h01, 1'b1, 4, 8'h01, 1, 0, 0, 1, 1, 0); idle();
        issue(4'd1, 8'h05, 8'h05, 1'b1, 5, 8'h00, 1, 0, 0, 1, 1, 0); idle();
        issue(4'd1, 8'h00, 8'h01, 1'b0, 6, 8'hFF, 0, 0, 0, 1, 1, 0); idle();
        issue(4'd1, 8'h80, 8'h01, 1'b0, 7, 8'h7F, 1, 1, 0, 1, 1, 0); idle();
        issue(4'd5, 8'h0F, 8'h00, 1'b0, 8, 8'hF0, 0, 0, 0, 1, 1, 0); idle();
        issue(4'd7, 8'hC1, 8'd2, 1'b0, 9, 8'h04, 1, 0, 0, 3, 1, 0); idle();
        issue(4'd8, 8'h01, 8'd1, 1'b0, 10, 8'h80, 0, 0, 0, 2, 1, 0); idle();
        issue(4'd9, 8'h81, 8'd1, 1'b0, 11, 8'h03, 0, 0, 0, 2, 1, 0); idle();
        issue(4'd7, 8'h03, 8'd7, 1'b0, 12, 8'h80, 1, 0, 0, 8, 1, 0); idle();
        issue(4'd6, 8'hA5, 8'h08, 1'b0, 13, 8'hA5, 0, 0, 0, 1, 1, 0); idle();
`ifdef ALU_MUL_EN
        issue(4'd10, 8'h10, 8'h10, 1'b0, 14, 8'h00, 1, 0, 0, 9, 1, 0); idle();
`else
        issue(4'd10, 8'h10, 8'h10, 1'b0, 14, 8'h00, 0, 0, 1, 1, 1, 0); idle();
`endif
        issue(4'd13, 8'h55, 8'h33, 1'b1, 15, 8'h00, 0, 0, 1, 1, 1, 0); idle();
        issue(4'd15, 8'hFF, 8'hFF, 1'b0, 16, 8'h00, 0, 0, 1, 1, 1, 0); idle();

        // starts while a k=5 shift is busy must be dropped
        issue(4'd6, 8'hF0, 8'd5, 1'b0, 17, 8'h07, 1, 0, 0, 6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; S = 4'd0; A = 8'h11; B = 8'h22;
            check("busy_ready", 17, 32'(ready), 32'(0));
        end
        idle();

        // back-to-back single-cycle ops complete on consecutive cycles
        issue(4'd2, 8'hCC, 8'hAA, 1'b0, 18, 8'h88, 0, 0, 0, 1, 1, 0);
        base = last_cyc;
        issue(4'd3, 8'hCC, 8'hAA, 1'b0, 19, 8'hEE, 0, 0, 0, 1, 1, base + 1);
        issue(4'd4, 8'hCC, 8'hAA, 1'b0, 20, 8'h66, 0, 0, 0, 1, 1, base + 2);
        idle();

        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("pending_empty", 0, 32'(sbq.size()), 32'(0));
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
